// File: rtl/poly_mul_stage.sv
// Polynomial multiply stage: selects the multiplicand and multiplier, forms the
// product as two carry-save words, resolves each CPA chunk, and registers the
// results. A separate bypass register forwards either byp_i or the constant 1.
module poly_mul_stage #(
    parameter int NumCoeffs = 4,
    parameter int WordBits  = 16,
    parameter int CpaBits   = 16,
    parameter int CpaCoeffs = 2 * NumCoeffs * WordBits / CpaBits
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumCoeffs*WordBits-1:0]        sqr_i,
    input  logic [NumCoeffs*WordBits-1:0]        mul_i,
    input  logic [NumCoeffs*WordBits-1:0]        byp_i,
    input  logic [NumCoeffs*WordBits-1:0]        byp_p1_i,
    input  logic                                 sel_byp_i,
    input  logic                                 sel_1_i,
    input  logic                                 adv_mul_i,
    input  logic                                 adv_byp_i,
    output logic [2*NumCoeffs*WordBits-1:0]      mul_product0_o,
    output logic [2*NumCoeffs*WordBits-1:0]      mul_product1_o,
    output logic [CpaCoeffs*(CpaBits+1)-1:0]     mul_cpa_product_o,
    output logic [NumCoeffs*WordBits-1:0]        byp_o
);

    localparam int Nb = NumCoeffs * WordBits;
    localparam int Pw = 2 * Nb;
    localparam int Cw = CpaBits + 1;

    // Constant 1 at operand width, used for the multiplier and bypass override.
    localparam logic [Nb-1:0] OneNb = {{(Nb-1){1'b0}}, 1'b1};

    logic [Nb-1:0]           a_s;
    logic [Nb-1:0]           b_s;
    logic [Nb-1:0]           byp_next_s;
    logic [Pw-1:0]           pp_s [NumCoeffs];
    logic [Pw-1:0]           sum_even_s;
    logic [Pw-1:0]           sum_odd_s;
    logic [CpaCoeffs*Cw-1:0] cpa_s;

    logic [Pw-1:0]           prod0_r;
    logic [Pw-1:0]           prod1_r;
    logic [CpaCoeffs*Cw-1:0] cpa_r;
    logic [Nb-1:0]           byp_r;

    // Operand selection; the constant-1 override wins over every other select.
    always_comb begin
        a_s        = sqr_i;
        b_s        = mul_i;
        byp_next_s = byp_i;
        if (sel_byp_i) begin
            a_s = byp_p1_i;
        end else begin
            a_s = sqr_i;
        end
        if (sel_1_i) begin
            b_s        = OneNb;
            byp_next_s = OneNb;
        end else begin
            b_s        = mul_i;
            byp_next_s = byp_i;
        end
    end

    // One partial product per multiplier coefficient, already shifted to its weight.
    for (genvar j = 0; j < NumCoeffs; j++) begin : g_pp
        assign pp_s[j] = (Pw'(a_s) * Pw'(b_s[j*WordBits +: WordBits])) << (j * WordBits);
    end

    // Carry-save split: even-indexed partial products accumulate into word 0,
    // odd-indexed ones into word 1. Each word is bounded by the full product,
    // so neither accumulation can wrap.
    always_comb begin
        sum_even_s = {Pw{1'b0}};
        sum_odd_s  = {Pw{1'b0}};
        for (int j = 0; j < NumCoeffs; j++) begin
            if (j[0] == 1'b0) begin
                sum_even_s = sum_even_s + pp_s[j];
            end else begin
                sum_odd_s = sum_odd_s + pp_s[j];
            end
        end
    end

    // Per-chunk carry-propagate add; carries stay local to each chunk.
    always_comb begin
        cpa_s = {(CpaCoeffs*Cw){1'b0}};
        for (int k = 0; k < CpaCoeffs; k++) begin
            cpa_s[k*Cw +: Cw] = {1'b0, sum_even_s[k*CpaBits +: CpaBits]}
                              + {1'b0, sum_odd_s[k*CpaBits +: CpaBits]};
        end
    end

    // Product registers: load on adv_mul_i, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod0_r <= {Pw{1'b0}};
            prod1_r <= {Pw{1'b0}};
            cpa_r   <= {(CpaCoeffs*Cw){1'b0}};
        end else if (adv_mul_i) begin
            prod0_r <= sum_even_s;
            prod1_r <= sum_odd_s;
            cpa_r   <= cpa_s;
        end else begin
            prod0_r <= prod0_r;
            prod1_r <= prod1_r;
            cpa_r   <= cpa_r;
        end
    end

    // Bypass register: independent of the product path, load on adv_byp_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byp_r <= {Nb{1'b0}};
        end else if (adv_byp_i) begin
            byp_r <= byp_next_s;
        end else begin
            byp_r <= byp_r;
        end
    end

    assign mul_product0_o    = prod0_r;
    assign mul_product1_o    = prod1_r;
    assign mul_cpa_product_o = cpa_r;
    assign byp_o             = byp_r;

endmodule

// File: tb/tb_poly_mul_stage.sv
// Randomized bench for poly_mul_stage with a behavioural product/bypass model.
module tb_poly_mul_stage;

    localparam int NB = 64;
    localparam int PW = 128;
    localparam int CB = 16;
    localparam int CC = 8;
    localparam int CW = 17;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NB-1:0]     sqr_i = '0, mul_i = '0, byp_i = '0, byp_p1_i = '0;
    logic              sel_byp_i = 1'b0, sel_1_i = 1'b0, adv_mul_i = 1'b0, adv_byp_i = 1'b0;
    logic [PW-1:0]     p0, p1;
    logic [CC*CW-1:0]  cpa;
    logic [NB-1:0]     byp_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    logic [PW-1:0] m_prod;
    logic [NB-1:0] m_byp;

    poly_mul_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sqr_i(sqr_i), .mul_i(mul_i), .byp_i(byp_i), .byp_p1_i(byp_p1_i),
        .sel_byp_i(sel_byp_i), .sel_1_i(sel_1_i),
        .adv_mul_i(adv_mul_i), .adv_byp_i(adv_byp_i),
        .mul_product0_o(p0), .mul_product1_o(p1),
        .mul_cpa_product_o(cpa), .byp_o(byp_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain integer multiply of the selected operands, plus the bypass value.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_prod <= '0;
            m_byp  <= '0;
        end else begin
            if (adv_mul_i)
                m_prod <= {64'd0, (sel_byp_i ? byp_p1_i : sqr_i)} * {64'd0, (sel_1_i ? 64'd1 : mul_i)};
            if (adv_byp_i)
                m_byp <= sel_1_i ? 64'd1 : byp_i;
        end
    end

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Chunk values implied by a carry-save pair.
    function automatic logic [CC*CW-1:0] chunks_of(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [CC*CW-1:0] r;
        r = '0;
        for (int k = 0; k < CC; k++)
            r[k*CW +: CW] = {1'b0, a[k*CB +: CB]} + {1'b0, b[k*CB +: CB]};
        return r;
    endfunction

    // Weighted sum of chunks, reduced to the product width.
    function automatic logic [PW-1:0] recon(input logic [CC*CW-1:0] c);
        logic [143:0] acc;
        acc = '0;
        for (int k = 0; k < CC; k++)
            acc = acc + (144'(c[k*CW +: CW]) << (k * CB));
        return acc[PW-1:0];
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (check_en) begin
            chk("sum",    144'(p0 + p1), 144'(m_prod));
            chk("byp",    144'(byp_o), 144'(m_byp));
            chk("chunks", 144'(cpa), 144'(chunks_of(p0, p1)));
            chk("recon",  144'(recon(cpa)), 144'(m_prod));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [NB-1:0] s, input logic [NB-1:0] m, input logic [NB-1:0] b,
                         input logic [NB-1:0] bp1, input logic sb, input logic s1,
                         input logic am, input logic ab);
        sqr_i = s; mul_i = m; byp_i = b; byp_p1_i = bp1;
        sel_byp_i = sb; sel_1_i = s1; adv_mul_i = am; adv_byp_i = ab;
    endtask

    initial begin
        logic [PW-1:0] big;
        logic [CC*CW-1:0] c15;
        logic [PW-1:0] held0, held1;
        logic [CC*CW-1:0] heldc;
        logic [NB-1:0] heldb;

        tick(); tick();
        chk("reset_p0",  144'(p0), 144'd0);
        chk("reset_cpa", 144'(cpa), 144'd0);
        rst_ni = 1'b1;
        check_en = 1'b1;

        // Idle after reset.
        repeat (3) tick();
        chk("idle_p0p1", 144'({p0, p1} != '0), 144'd0);
        chk("idle_byp",  144'(byp_o), 144'd0);

        // 3 * 5.
        drive(64'd3, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        adv_mul_i = 1'b0;
        c15 = '0; c15[CW-1:0] = 17'd15;
        chk("d15_sum",   144'(p0 + p1), 144'd15);
        chk("d15_model", 144'(m_prod), 144'd15);
        chk("d15_cpa",   144'(cpa), 144'(c15));

        // All-ones squared.
        drive({NB{1'b1}}, {NB{1'b1}}, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        adv_mul_i = 1'b0;
        big = 128'hFFFFFFFF_FFFFFFFE_00000000_00000001;
        chk("ones_sum",   144'(p0 + p1), 144'(big));
        chk("ones_model", 144'(m_prod), 144'(big));

        // Constant-1 override on both paths.
        drive(64'h1234, 64'd99, 64'h55, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        drive(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("one_sum", 144'(p0 + p1), 144'h1234);
        chk("one_byp", 144'(byp_o), 144'd1);

        // Alternate multiplicand plus simultaneous bypass load.
        drive(64'd9, 64'd6, 64'hAB, 64'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("alt_sum", 144'(p0 + p1), 144'd42);
        chk("alt_byp", 144'(byp_o), 144'hAB);
        held0 = p0; held1 = p1; heldc = cpa; heldb = byp_o;

        // Hold for 5 cycles while inputs toggle.
        for (int i = 0; i < 5; i++) begin
            drive({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            tick();
        end
        chk("hold_p0",  144'(p0), 144'(held0));
        chk("hold_p1",  144'(p1), 144'(held1));
        chk("hold_cpa", 144'(cpa), 144'(heldc));
        chk("hold_byp", 144'(byp_o), 144'(heldb));

        // Mid-cycle reset clears immediately and holds through an edge with adv set.
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_p0p1", 144'({p0, p1} != '0), 144'd0);
        chk("arst_cpa",  144'(cpa), 144'd0);
        chk("arst_byp",  144'(byp_o), 144'd0);
        drive(64'd11, 64'd13, 64'h77, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rst_hold_p0p1", 144'({p0, p1} != '0), 144'd0);
        chk("rst_hold_byp",  144'(byp_o), 144'd0);
        #4;
        rst_ni = 1'b1;
        tick();
        chk("fresh_sum", 144'(p0 + p1), 144'd143);
        chk("fresh_byp", 144'(byp_o), 144'h77);

        // Randomized traffic with occasional extreme operands.
        for (int i = 0; i < 400; i++) begin
            logic [NB-1:0] s, m;
            s = {$urandom, $urandom};
            m = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) s = {NB{1'b1}};
            if ($urandom_range(0, 7) == 0) m = {NB{1'b1}};
            if ($urandom_range(0, 9) == 0) m = '0;
            drive(s, m, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            tick();
        end
        drive(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk_i);
        #1;
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
